// File: rtl/accel_pkg.sv
// Shared definitions for the inference-pipeline tail blocks: default sizes,
// sign-magnitude field helpers and the classifier state encoding.
`ifndef ACCEL_SM_MACROS
`define ACCEL_SM_MACROS
`define SM_SIGN(w) ((w)-1)
`define SM_MAG(w) ((w)-2):0
`endif

package accel_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_NUM_CLASSES = 10;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_IDX_WIDTH = idx_width(DEF_NUM_CLASSES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fc_argmax_classifier_if.sv
// Score-capture and result handshake bundle between the FC layer, the
// argmax classifier and the downstream consumer.
interface fc_argmax_classifier_if
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH
);

   logic                              start;
   logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in;
   logic                              out_ready;
   logic                              out_valid;
   logic [IDX_WIDTH-1:0]              class_id;
   logic [DATA_WIDTH-1:0]             max_score;
   logic                              busy;
   logic                              overrun;

   modport master (
      output start, scores_in, out_ready,
      input  out_valid, class_id, max_score, busy, overrun
   );

   modport slave (
      input  start, scores_in, out_ready,
      output out_valid, class_id, max_score, busy, overrun
   );

endinterface

// File: rtl/sm_greater_than.sv
// Combinational strict greater-than for sign-magnitude values; +0 and -0
// compare equal and no arithmetic is done on the operands.
module sm_greater_than
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  gt
);

   logic                  a_neg;
   logic                  b_neg;
   logic [DATA_WIDTH-2:0] a_mag;
   logic [DATA_WIDTH-2:0] b_mag;
   logic                  a_zero;
   logic                  b_zero;

   assign a_neg  = a[`SM_SIGN(DATA_WIDTH)];
   assign b_neg  = b[`SM_SIGN(DATA_WIDTH)];
   assign a_mag  = a[`SM_MAG(DATA_WIDTH)];
   assign b_mag  = b[`SM_MAG(DATA_WIDTH)];
   assign a_zero = (a_mag == '0);
   assign b_zero = (b_mag == '0);

   // Only the both-zero case needs special handling; a lone -0 falls
   // through the sign/magnitude paths with the correct ordering.
   always_comb begin
      if (a_zero && b_zero) begin
         gt = 1'b0;
      end else if (a_neg != b_neg) begin
         gt = !a_neg;
      end else if (!a_neg) begin
         gt = (a_mag > b_mag);
      end else begin
         gt = (a_mag < b_mag);
      end
   end

endmodule

// File: rtl/fc_argmax_classifier.sv
// Captures the FC layer's class scores on its done pulse, scans them one per
// cycle and holds the winning index/score under a valid/ready handshake.
module fc_argmax_classifier
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int IDX_WIDTH   = idx_width(NUM_CLASSES)
) (
   input logic                   clk,
   input logic                   rst,
   fc_argmax_classifier_if.slave bus
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   logic [DATA_WIDTH-1:0] bank [NUM_CLASSES];
   state_t                state;
   logic [IDX_WIDTH-1:0]  idx;
   logic [IDX_WIDTH-1:0]  best_idx;
   logic [DATA_WIDTH-1:0] best;
   logic [DATA_WIDTH-1:0] cur;
   logic                  cur_gt;
   logic                  load;

   logic                  valid_q;
   logic [IDX_WIDTH-1:0]  class_q;
   logic [DATA_WIDTH-1:0] max_q;
   logic                  busy_q;
   logic                  overrun_q;

   always_comb begin
      cur = '0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (idx == IDX_WIDTH'(k)) begin
            cur = bank[k];
         end
      end
   end

   sm_greater_than #(.DATA_WIDTH(DATA_WIDTH)) u_gt (
      .a  (cur),
      .b  (best),
      .gt (cur_gt)
   );

   // A start is taken when idle, or when it coincides with the result being
   // consumed; any other start is dropped and flagged.
   assign load = bus.start &&
                 ((state == IDLE) || ((state == DONE) && valid_q && bus.out_ready));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         best_idx  <= '0;
         best      <= '0;
         valid_q   <= 1'b0;
         class_q   <= '0;
         max_q     <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            bank[k] <= '0;
         end
      end else begin
         overrun_q <= bus.start && !load && (state != IDLE);
         if (load) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
               bank[k] <= bus.scores_in[DATA_WIDTH*k +: DATA_WIDTH];
            end
            best     <= bus.scores_in[DATA_WIDTH-1:0];
            best_idx <= '0;
            idx      <= IDX_WIDTH'(1);
            state    <= SCAN;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               SCAN: begin
                  if (cur_gt) begin
                     best     <= cur;
                     best_idx <= idx;
                  end
                  if (idx == LAST_IDX) begin
                     state   <= DONE;
                     valid_q <= 1'b1;
                     class_q <= cur_gt ? idx : best_idx;
                     max_q   <= cur_gt ? cur : best;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               DONE: begin
                  if (valid_q && bus.out_ready) begin
                     state   <= IDLE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.class_id  = class_q;
   assign bus.max_score = max_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: table vectors, random vectors
// against a signed-integer reference, and handshake/overrun/reset sequences.
`timescale 1ns/1ps
module tb_fc_argmax_classifier;
   import accel_pkg::*;

   localparam int DW = 16;
   localparam int NC = 10;
   localparam int IW = 4;
   localparam int MW = DW - 1;

   typedef logic [DW-1:0] score_arr_t [NC];
   typedef struct {
      score_arr_t     s;
      logic [IW-1:0]  cid;
      logic [DW-1:0]  mx;
   } vec_t;
   typedef struct {
      logic [IW-1:0]  cid;
      logic [DW-1:0]  mx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fc_argmax_classifier_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) bus ();

   fc_argmax_classifier #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] sm(input int v);
      if (v < 0) return {1'b1, MW'(-v)};
      return {1'b0, MW'(v)};
   endfunction

   function automatic int to_int(input logic [DW-1:0] x);
      int m;
      m = int'(x[DW-2:0]);
      return x[DW-1] ? -m : m;
   endfunction

   function automatic logic [NC*DW-1:0] pack(input score_arr_t s);
      logic [NC*DW-1:0] p;
      for (int k = 0; k < NC; k++) p[DW*k +: DW] = s[k];
      return p;
   endfunction

   function automatic exp_t model(input score_arr_t s);
      exp_t e;
      int   bv;
      int   v;
      e.cid = '0;
      e.mx  = s[0];
      bv    = to_int(s[0]);
      for (int k = 1; k < NC; k++) begin
         v = to_int(s[k]);
         if (v > bv) begin
            bv    = v;
            e.cid = IW'(k);
            e.mx  = s[k];
         end
      end
      return e;
   endfunction

   // Drives start for the following edge; the caller clears it after step().
   task automatic issue(input score_arr_t s, input exp_t e, input bit push);
      bus.scores_in = pack(s);
      bus.start     = 1'b1;
      if (push) sb_q.push_back(e);
   endtask

   task automatic collect(input string name, input int already, output exp_t got);
      int   lat;
      exp_t e;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({name, "_latency"}, 32'(lat + 1 + already), 32'(NC));
      got.cid = bus.class_id;
      got.mx  = bus.max_score;
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check({name, "_class_id"}, 32'(bus.class_id), 32'(e.cid));
         check({name, "_max_score"}, 32'(bus.max_score), 32'(e.mx));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t       vecs [7];
   score_arr_t rs;
   exp_t       e;
   exp_t       got;
   exp_t       held;
   bit         stable;

   initial begin
      vecs[0].s = '{sm(3), sm(9), sm(-4), sm(12), sm(0), sm(7), sm(1), sm(2), sm(5), sm(6)};
      vecs[0].cid = 4'd3;  vecs[0].mx = 16'h000C;
      vecs[1].s = '{sm(-5), sm(-2), sm(-9), sm(-7), sm(-3), sm(-8), sm(-6), sm(-2), sm(-4), sm(-10)};
      vecs[1].cid = 4'd1;  vecs[1].mx = 16'h8002;
      vecs[2].s = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      vecs[2].cid = 4'd0;  vecs[2].mx = 16'h8000;
      vecs[3].s = '{16'h0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h8000, 16'h8000, 16'h8000};
      vecs[3].cid = 4'd0;  vecs[3].mx = 16'h0000;
      vecs[4].s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                    16'hFFFF, 16'hFFFF, 16'h7FFF};
      vecs[4].cid = 4'd9;  vecs[4].mx = 16'h7FFF;
      vecs[5].s = '{sm(7), sm(7), sm(7), sm(7), sm(7), sm(7), sm(7), sm(7), sm(7), sm(7)};
      vecs[5].cid = 4'd0;  vecs[5].mx = 16'h0007;
      vecs[6].s = '{sm(-3), sm(-1), sm(-2), 16'h8000, sm(-5), sm(-4), sm(-6), sm(-7), sm(-8), sm(-9)};
      vecs[6].cid = 4'd3;  vecs[6].mx = 16'h8000;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.scores_in = '0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_class_id", 32'(bus.class_id), 32'd0);
      check("rst_max_score", 32'(bus.max_score), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      step();

      // Table vectors with the consumer always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         e.cid = vecs[i].cid;
         e.mx  = vecs[i].mx;
         issue(vecs[i].s, e, 1'b1);
         step();
         bus.start = 1'b0;
         check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
         collect($sformatf("vec%0d", i), 0, got);
         step();
         check($sformatf("vec%0d_valid_drop", i), 32'(bus.out_valid), 32'd0);
      end

      // Random vectors against the signed-integer reference; small magnitudes force ties.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < NC; k++) begin
            if (i < 4) rs[k] = {1'($urandom_range(1)), MW'($urandom_range(3))};
            else       rs[k] = DW'($urandom);
         end
         issue(rs, model(rs), 1'b1);
         step();
         bus.start = 1'b0;
         collect($sformatf("rnd%0d", i), 0, got);
         step();
      end

      // Consumer stalls 20 cycles; a start mid-stall is dropped.
      bus.out_ready = 1'b0;
      e.cid = vecs[0].cid;  e.mx = vecs[0].mx;
      issue(vecs[0].s, e, 1'b1);
      step();
      bus.start = 1'b0;
      collect("stall", 0, held);
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            bus.scores_in = pack(vecs[4].s);
            bus.start = 1'b1;
         end
         step();
         bus.start = 1'b0;
         if (c == 5) check("stall_overrun_pulse", 32'(bus.overrun), 32'd1);
         if (c == 6) check("stall_overrun_clear", 32'(bus.overrun), 32'd0);
         if (!bus.out_valid || bus.class_id !== held.cid || bus.max_score !== held.mx) stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 32'd1);
      check("stall_class_kept", 32'(bus.class_id), 32'd3);
      bus.out_ready = 1'b1;
      step();
      check("stall_release", 32'(bus.out_valid), 32'd0);

      // Start coincident with the completing handshake.
      bus.out_ready = 1'b0;
      e.cid = vecs[1].cid;  e.mx = vecs[1].mx;
      issue(vecs[1].s, e, 1'b1);
      step();
      bus.start = 1'b0;
      collect("b2b_first", 0, got);
      bus.out_ready = 1'b1;
      e.cid = vecs[6].cid;  e.mx = vecs[6].mx;
      issue(vecs[6].s, e, 1'b1);
      step();
      bus.start = 1'b0;
      check("b2b_no_overrun", 32'(bus.overrun), 32'd0);
      check("b2b_valid_low", 32'(bus.out_valid), 32'd0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      collect("b2b_second", 0, got);
      step();

      // Start during SCAN is dropped and does not disturb the bank.
      e.cid = vecs[0].cid;  e.mx = vecs[0].mx;
      issue(vecs[0].s, e, 1'b1);
      step();
      bus.start = 1'b0;
      step();
      step();
      bus.scores_in = pack(vecs[4].s);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("scan_overrun_pulse", 32'(bus.overrun), 32'd1);
      step();
      check("scan_overrun_clear", 32'(bus.overrun), 32'd0);
      collect("scan_drop", 4, got);
      step();

      // Asynchronous reset mid-scan, then a fresh transaction.
      e.cid = vecs[4].cid;  e.mx = vecs[4].mx;
      issue(vecs[4].s, e, 1'b0);
      step();
      bus.start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_class_id", 32'(bus.class_id), 32'd0);
      check("abort_max_score", 32'(bus.max_score), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      e.cid = vecs[1].cid;  e.mx = vecs[1].mx;
      issue(vecs[1].s, e, 1'b1);
      step();
      bus.start = 1'b0;
      collect("after_abort", 0, got);
      step();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
